// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, opcodes
// and the datapath select values driven by the controller.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      EXEC_R = 4'd2,
      EXEC_I = 4'd3,
      WB_ALU = 4'd4,
      ADDR   = 4'd5,
      MEM_RD = 4'd6,
      MEM_WR = 4'd7,
      WB_MEM = 4'd8,
      BRANCH = 4'd9,
      JUMP   = 4'd10,
      JR     = 4'd11,
      FAULT  = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_BLEZ  = 6'h06;
   localparam logic [5:0] OP_BGTZ  = 6'h07;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] FUNCT_JR = 6'h08;

   localparam logic [2:0] ALU_ADD   = 3'd0;
   localparam logic [2:0] ALU_SUB   = 3'd1;
   localparam logic [2:0] ALU_RTYPE = 3'd2;
   localparam logic [2:0] ALU_SLT   = 3'd3;
   localparam logic [2:0] ALU_OR    = 3'd4;
   localparam logic [2:0] ALU_LUI   = 3'd5;

   localparam logic [1:0] PC_ALU    = 2'd0;
   localparam logic [1:0] PC_ALUOUT = 2'd1;
   localparam logic [1:0] PC_JUMP   = 2'd2;
   localparam logic [1:0] PC_RS     = 2'd3;

   localparam logic [1:0] SRCB_RT     = 2'd0;
   localparam logic [1:0] SRCB_FOUR   = 2'd1;
   localparam logic [1:0] SRCB_IMM    = 2'd2;
   localparam logic [1:0] SRCB_IMM_SH = 2'd3;

   localparam logic [1:0] DST_RT  = 2'd0;
   localparam logic [1:0] DST_RD  = 2'd1;
   localparam logic [1:0] DST_R31 = 2'd2;

   localparam logic [1:0] WD_ALUOUT = 2'd0;
   localparam logic [1:0] WD_MDR    = 2'd1;
   localparam logic [1:0] WD_PC     = 2'd2;

endpackage

// File: rtl/mc_branch_eval.sv
// Branch-taken decision for beq/bne/blez/bgtz from the ALU subtract flags.
module mc_branch_eval
   import mc_ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       neg,
   output logic       taken
);

   // Condition select per branch opcode; anything else never branches
   always_comb begin
      taken = 1'b0;
      case (opcode)
         OP_BEQ:  taken = zero;
         OP_BNE:  taken = ~zero;
         OP_BLEZ: taken = neg | zero;
         OP_BGTZ: taken = ~neg & ~zero;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and a single variable-latency memory port.
module multicycle_ctrl
   import mc_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [5:0] opcode_i,
   input  logic [5:0] funct_i,
   input  logic       zero_i,
   input  logic       neg_i,
   input  logic       mem_ready_i,
   output logic       mem_req_o,
   output logic       mem_write_o,
   output logic       iord_o,
   output logic       ir_write_o,
   output logic       pc_write_o,
   output logic [1:0] pc_src_o,
   output logic       alu_src_a_o,
   output logic [1:0] alu_src_b_o,
   output logic [2:0] alu_op_o,
   output logic       ext_sel_o,
   output logic [1:0] reg_dst_o,
   output logic [1:0] mem_to_reg_o,
   output logic       reg_write_o,
   output logic       fault_o,
   output logic [3:0] state_o
);

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic             wb_rd;
   logic             taken;
   logic             timeout;

   mc_branch_eval u_branch_eval (
      .opcode (opcode_i),
      .zero   (zero_i),
      .neg    (neg_i),
      .taken  (taken)
   );

   // The request gives up on the last permitted wait cycle unless ready arrives then
   assign timeout = (wait_cnt == CNT_W'(MEM_TIMEOUT - 1)) && !mem_ready_i;
   assign state_o = state;

   // State sequencing, memory wait counter and writeback destination memory
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= FETCH;
         wait_cnt <= '0;
         wb_rd    <= 1'b0;
      end else begin
         wait_cnt <= '0;
         case (state)
            FETCH: begin
               if (mem_ready_i) state <= DECODE;
               else if (timeout) state <= FAULT;
               else wait_cnt <= wait_cnt + CNT_W'(1);
            end
            DECODE: begin
               case (opcode_i)
                  OP_RTYPE: state <= (funct_i == FUNCT_JR) ? JR : EXEC_R;
                  OP_LW, OP_SW: state <= ADDR;
                  OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: state <= BRANCH;
                  OP_ADDI, OP_SLTI, OP_ORI, OP_LUI: state <= EXEC_I;
                  OP_J, OP_JAL: state <= JUMP;
                  default: state <= FAULT;
               endcase
            end
            EXEC_R: begin
               wb_rd <= 1'b1;
               state <= WB_ALU;
            end
            EXEC_I: begin
               wb_rd <= 1'b0;
               state <= WB_ALU;
            end
            ADDR: state <= (opcode_i == OP_SW) ? MEM_WR : MEM_RD;
            MEM_RD: begin
               if (mem_ready_i) state <= WB_MEM;
               else if (timeout) state <= FAULT;
               else wait_cnt <= wait_cnt + CNT_W'(1);
            end
            MEM_WR: begin
               if (mem_ready_i) state <= FETCH;
               else if (timeout) state <= FAULT;
               else wait_cnt <= wait_cnt + CNT_W'(1);
            end
            WB_ALU, WB_MEM, BRANCH, JUMP, JR: state <= FETCH;
            FAULT:   state <= FAULT;
            default: state <= FAULT;
         endcase
      end
   end

   // Datapath control decode; reset forces every strobe and select low
   always_comb begin
      mem_req_o    = 1'b0;
      mem_write_o  = 1'b0;
      iord_o       = 1'b0;
      ir_write_o   = 1'b0;
      pc_write_o   = 1'b0;
      pc_src_o     = PC_ALU;
      alu_src_a_o  = 1'b0;
      alu_src_b_o  = SRCB_RT;
      alu_op_o     = ALU_ADD;
      ext_sel_o    = 1'b0;
      reg_dst_o    = DST_RT;
      mem_to_reg_o = WD_ALUOUT;
      reg_write_o  = 1'b0;
      fault_o      = 1'b0;
      if (rst_i) begin
         fault_o = 1'b0;
      end else begin
         case (state)
            FETCH: begin
               mem_req_o   = 1'b1;
               alu_src_b_o = SRCB_FOUR;
               ir_write_o  = mem_ready_i;
               pc_write_o  = mem_ready_i;
            end
            DECODE: alu_src_b_o = SRCB_IMM_SH;
            EXEC_R: begin
               alu_src_a_o = 1'b1;
               alu_op_o    = ALU_RTYPE;
               reg_dst_o   = DST_RD;
            end
            EXEC_I: begin
               alu_src_a_o = 1'b1;
               alu_src_b_o = SRCB_IMM;
               case (opcode_i)
                  OP_SLTI: alu_op_o = ALU_SLT;
                  OP_ORI: begin
                     alu_op_o  = ALU_OR;
                     ext_sel_o = 1'b1;
                  end
                  OP_LUI: begin
                     alu_op_o  = ALU_LUI;
                     ext_sel_o = 1'b1;
                  end
                  default: alu_op_o = ALU_ADD;
               endcase
            end
            WB_ALU: begin
               reg_write_o = 1'b1;
               reg_dst_o   = wb_rd ? DST_RD : DST_RT;
            end
            ADDR: begin
               alu_src_a_o = 1'b1;
               alu_src_b_o = SRCB_IMM;
            end
            MEM_RD: begin
               mem_req_o = 1'b1;
               iord_o    = 1'b1;
            end
            MEM_WR: begin
               mem_req_o   = 1'b1;
               mem_write_o = 1'b1;
               iord_o      = 1'b1;
            end
            WB_MEM: begin
               reg_write_o  = 1'b1;
               mem_to_reg_o = WD_MDR;
            end
            BRANCH: begin
               alu_src_a_o = 1'b1;
               alu_op_o    = ALU_SUB;
               pc_src_o    = PC_ALUOUT;
               pc_write_o  = taken;
            end
            JUMP: begin
               pc_write_o = 1'b1;
               pc_src_o   = PC_JUMP;
               if (opcode_i == OP_JAL) begin
                  reg_write_o  = 1'b1;
                  reg_dst_o    = DST_R31;
                  mem_to_reg_o = WD_PC;
               end else begin
                  reg_write_o = 1'b0;
               end
            end
            JR: begin
               pc_write_o = 1'b1;
               pc_src_o   = PC_RS;
            end
            FAULT:   fault_o = 1'b1;
            default: fault_o = 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle state and control-vector checks
// against hand-derived expectations for each instruction class.
module tb_multicycle_ctrl;
   import mc_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst_i = 1'b1;
   logic [5:0] opcode_i = 6'h00;
   logic [5:0] funct_i = 6'h00;
   logic       zero_i = 1'b0;
   logic       neg_i = 1'b0;
   logic       mem_ready_i = 1'b0;
   logic       mem_req_o, mem_write_o, iord_o, ir_write_o, pc_write_o;
   logic [1:0] pc_src_o, alu_src_b_o, reg_dst_o, mem_to_reg_o;
   logic       alu_src_a_o, ext_sel_o, reg_write_o, fault_o;
   logic [2:0] alu_op_o;
   logic [3:0] state_o;

   int n_vec = 0;
   int n_err = 0;

   logic [19:0] obs;
   logic [19:0] f_wait, f_go, dec, addr_p, mrd_p, mwr_p, flt_p;

   multicycle_ctrl #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
      .clk_i(clk), .rst_i(rst_i), .opcode_i(opcode_i), .funct_i(funct_i),
      .zero_i(zero_i), .neg_i(neg_i), .mem_ready_i(mem_ready_i),
      .mem_req_o(mem_req_o), .mem_write_o(mem_write_o), .iord_o(iord_o),
      .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .pc_src_o(pc_src_o),
      .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
      .ext_sel_o(ext_sel_o), .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o),
      .reg_write_o(reg_write_o), .fault_o(fault_o), .state_o(state_o)
   );

   always #5 clk = ~clk;

   assign obs = {mem_req_o, mem_write_o, iord_o, ir_write_o, pc_write_o, pc_src_o,
                 alu_src_a_o, alu_src_b_o, alu_op_o, ext_sel_o, reg_dst_o,
                 mem_to_reg_o, reg_write_o, fault_o};

   function automatic logic [19:0] pk(input int req, wr, iord, irw, pcw, pcs, asa,
                                      asb, op, ext, rd, m2r, rw, flt);
      return {1'(req), 1'(wr), 1'(iord), 1'(irw), 1'(pcw), 2'(pcs), 1'(asa),
              2'(asb), 3'(op), 1'(ext), 2'(rd), 2'(m2r), 1'(rw), 1'(flt)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock: apply ready, check state and controls mid-cycle, advance
   task automatic cyc(input logic rdy, input string tag, input state_t st, input logic [19:0] e);
      mem_ready_i = rdy;
      #2;
      chk({tag, "_st"}, 32'(state_o), 32'(st));
      chk(tag, 32'(obs), 32'(e));
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input string tag);
      rst_i = 1'b1;
      mem_ready_i = 1'b1;
      #2;
      chk({tag, "_rstcyc"}, 32'(obs), 32'(0));
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      chk({tag, "_rst_st"}, 32'(state_o), 32'(FETCH));
   endtask

   task automatic branch(input logic [5:0] op, input logic z, input logic n,
                         input int tk, input string tag);
      opcode_i = op; zero_i = z; neg_i = n;
      cyc(1'b1, {tag, "_f"}, FETCH, f_go);
      cyc(1'b1, {tag, "_d"}, DECODE, dec);
      cyc(1'b1, tag, BRANCH, pk(0,0,0,0,tk,1,1,0,1,0,0,0,0,0));
   endtask

   initial begin
      f_wait = pk(1,0,0,0,0,0,0,1,0,0,0,0,0,0);
      f_go   = pk(1,0,0,1,1,0,0,1,0,0,0,0,0,0);
      dec    = pk(0,0,0,0,0,0,0,3,0,0,0,0,0,0);
      addr_p = pk(0,0,0,0,0,0,1,2,0,0,0,0,0,0);
      mrd_p  = pk(1,0,1,0,0,0,0,0,0,0,0,0,0,0);
      mwr_p  = pk(1,1,1,0,0,0,0,0,0,0,0,0,0,0);
      flt_p  = pk(0,0,0,0,0,0,0,0,0,0,0,0,0,1);

      @(posedge clk);
      #1;
      #2;
      chk("rst_outs", 32'(obs), 32'(0));
      chk("rst_st", 32'(state_o), 32'(FETCH));
      @(posedge clk);
      #1;
      rst_i = 1'b0;

      // add: 4 cycles, one reg_write to rd
      opcode_i = OP_RTYPE; funct_i = 6'h20;
      cyc(1'b1, "add_f", FETCH, f_go);
      cyc(1'b1, "add_d", DECODE, dec);
      cyc(1'b1, "add_x", EXEC_R, pk(0,0,0,0,0,0,1,0,2,0,1,0,0,0));
      cyc(1'b1, "add_wb", WB_ALU, pk(0,0,0,0,0,0,0,0,0,0,1,0,1,0));

      // lw with 3 fetch waits and 2 read waits: writeback on cycle 10
      opcode_i = OP_LW;
      for (int i = 0; i < 3; i++) cyc(1'b0, "lw_fwait", FETCH, f_wait);
      cyc(1'b1, "lw_f", FETCH, f_go);
      cyc(1'b1, "lw_d", DECODE, dec);
      cyc(1'b1, "lw_a", ADDR, addr_p);
      for (int i = 0; i < 2; i++) cyc(1'b0, "lw_mwait", MEM_RD, mrd_p);
      cyc(1'b1, "lw_m", MEM_RD, mrd_p);
      cyc(1'b1, "lw_wb", WB_MEM, pk(0,0,0,0,0,0,0,0,0,0,0,1,1,0));

      branch(OP_BEQ, 1'b1, 1'b0, 1, "beq_z1");
      branch(OP_BNE, 1'b1, 1'b0, 0, "bne_z1");
      branch(OP_BLEZ, 1'b0, 1'b1, 1, "blez_n1");
      branch(OP_BGTZ, 1'b0, 1'b1, 0, "bgtz_n1");
      branch(OP_BGTZ, 1'b0, 1'b0, 1, "bgtz_pos");

      opcode_i = OP_JAL;
      cyc(1'b1, "jal_f", FETCH, f_go);
      cyc(1'b1, "jal_d", DECODE, dec);
      cyc(1'b1, "jal_j", JUMP, pk(0,0,0,0,1,2,0,0,0,0,2,2,1,0));
      opcode_i = OP_J;
      cyc(1'b1, "j_f", FETCH, f_go);
      cyc(1'b1, "j_d", DECODE, dec);
      cyc(1'b1, "j_j", JUMP, pk(0,0,0,0,1,2,0,0,0,0,0,0,0,0));
      opcode_i = OP_RTYPE; funct_i = FUNCT_JR;
      cyc(1'b1, "jr_f", FETCH, f_go);
      cyc(1'b1, "jr_d", DECODE, dec);
      cyc(1'b1, "jr_j", JR, pk(0,0,0,0,1,3,0,0,0,0,0,0,0,0));

      opcode_i = OP_ORI;
      cyc(1'b1, "ori_f", FETCH, f_go);
      cyc(1'b1, "ori_d", DECODE, dec);
      cyc(1'b1, "ori_x", EXEC_I, pk(0,0,0,0,0,0,1,2,4,1,0,0,0,0));
      cyc(1'b1, "ori_wb", WB_ALU, pk(0,0,0,0,0,0,0,0,0,0,0,0,1,0));
      opcode_i = OP_SLTI;
      cyc(1'b1, "slti_f", FETCH, f_go);
      cyc(1'b1, "slti_d", DECODE, dec);
      cyc(1'b1, "slti_x", EXEC_I, pk(0,0,0,0,0,0,1,2,3,0,0,0,0,0));
      cyc(1'b1, "slti_wb", WB_ALU, pk(0,0,0,0,0,0,0,0,0,0,0,0,1,0));

      // lui aborted by reset in its writeback cycle
      opcode_i = OP_LUI;
      cyc(1'b1, "lui_f", FETCH, f_go);
      cyc(1'b1, "lui_d", DECODE, dec);
      cyc(1'b1, "lui_x", EXEC_I, pk(0,0,0,0,0,0,1,2,5,1,0,0,0,0));
      do_reset("lui_abort");

      // sw: ready on the last allowed wait cycle completes normally
      opcode_i = OP_SW;
      cyc(1'b1, "sw_f", FETCH, f_go);
      cyc(1'b1, "sw_d", DECODE, dec);
      cyc(1'b1, "sw_a", ADDR, addr_p);
      for (int i = 0; i < 14; i++) cyc(1'b0, "sw_wait", MEM_WR, mwr_p);
      cyc(1'b1, "sw_m", MEM_WR, mwr_p);
      cyc(1'b0, "sw_next", FETCH, f_wait);

      // sw: ready withheld 15 cycles faults
      cyc(1'b1, "swt_f", FETCH, f_go);
      cyc(1'b1, "swt_d", DECODE, dec);
      cyc(1'b1, "swt_a", ADDR, addr_p);
      for (int i = 0; i < 15; i++) cyc(1'b0, "swt_wait", MEM_WR, mwr_p);
      cyc(1'b1, "swt_flt", FAULT, flt_p);
      cyc(1'b1, "swt_sticky", FAULT, flt_p);
      do_reset("swt");
      cyc(1'b0, "post_rst", FETCH, f_wait);

      opcode_i = 6'h3F;
      cyc(1'b1, "ill_f", FETCH, f_go);
      cyc(1'b1, "ill_d", DECODE, dec);
      cyc(1'b1, "ill_flt", FAULT, flt_p);
      cyc(1'b0, "ill_sticky", FAULT, flt_p);
      do_reset("ill");
      opcode_i = OP_RTYPE; funct_i = 6'h20;
      cyc(1'b1, "ill_recover", FETCH, f_go);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM that turns the single-cycle MIPS datapath into a multi-cycle one sharing one ALU and one unified memory port.
- Sequences fetch, decode, execute, memory and writeback, one step per cycle or more.
- Drives every datapath mux select and write enable.
- Handles a variable-latency memory through a req/ready handshake with a watchdog timeout.

Parameters:
- MEM_TIMEOUT, 15: max cycles a memory request may wait for mem_ready_i before the FSM faults.
- CNT_W, 4: width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- opcode_i  in  6  instruction[31:26] from the IR.
- funct_i  in  6  instruction[5:0] from the IR.
- zero_i  in  1  ALU zero flag.
- neg_i  in  1  ALU result[31].
- mem_ready_i  in  1  memory completes the current request this cycle.
- mem_req_o  out  1  memory request valid.
- mem_write_o  out  1  with mem_req_o: 1 = store, 0 = read.
- iord_o  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write_o  out  1  load the IR from memory data.
- pc_write_o  out  1  load the PC.
- pc_src_o  out  2  next PC: 0 = ALU result, 1 = ALUOut (branch target), 2 = {PC[31:28], IR[25:0], 00}, 3 = RS.
- alu_src_a_o  out  1  ALU A operand: 0 = PC, 1 = RS.
- alu_src_b_o  out  2  ALU B operand: 0 = RT, 1 = 4, 2 = extended immediate, 3 = extended immediate << 2.
- alu_op_o  out  3  ALUOp to ALU_Ctrl: 0 = add, 1 = sub, 2 = R-type (funct), 3 = slt, 4 = or, 5 = lui.
- ext_sel_o  out  1  immediate extension: 0 = sign, 1 = zero.
- reg_dst_o  out  2  write register: 0 = rt, 1 = rd, 2 = r31.
- mem_to_reg_o  out  2  write data: 0 = ALUOut, 1 = MDR, 2 = PC.
- reg_write_o  out  1  register file write enable.
- fault_o  out  1  sticky; set on illegal opcode or memory timeout.
- state_o  out  4  current state, for debug.

Behaviour:
- Reset (synchronous, active-high):
  - state = FETCH, wait counter = 0, fault_o = 0.
  - All strobe outputs are 0: mem_req, mem_write, ir_write, pc_write, reg_write.
  - All selects are 0.
- All outputs are a combinational (Moore/Mealy) decode of state, IR fields and the mem_ready_i/zero_i/neg_i inputs. Strobes are only ever asserted for one cycle per event.
- FETCH:
  - Drive mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=add.
  - When mem_ready_i=1: ir_write=1, pc_write=1, pc_src=0, go to DECODE.
  - Otherwise stay in FETCH and increment the counter.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=add (branch target into ALUOut). Dispatch on opcode:
  - R-type (0x00): funct 0x08 (jr) -> JR; all other funct -> EXEC_R.
  - lw (0x23), sw (0x2B) -> ADDR.
  - beq/bne/blez/bgtz (0x04–0x07) -> BRANCH.
  - addi (0x08), slti (0x0A), ori (0x0D), lui (0x0F) -> EXEC_I.
  - j (0x02), jal (0x03) -> JUMP.
  - Any other opcode -> FAULT.
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_op=2, go to WB_ALU with reg_dst=1.
- EXEC_I: alu_src_a=1, alu_src_b=2, go to WB_ALU with reg_dst=0.
  - addi: op=add, ext=0. slti: op=slt, ext=0. ori: op=or, ext=1. lui: op=lui, ext=1.
- WB_ALU: reg_write=1, mem_to_reg=0, go to FETCH. reg_dst is the value selected in the preceding EXEC state.
- ADDR: alu_src_a=1, alu_src_b=2, op=add, ext=0. lw -> MEM_RD, sw -> MEM_WR.
- MEM_RD: mem_req=1, iord=1. On ready -> WB_MEM.
- MEM_WR: mem_req=1, mem_write=1, iord=1. On ready -> FETCH.
- WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1, go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, op=sub, pc_src=1. Compute taken:
  - beq: zero_i. bne: !zero_i. blez: neg_i | zero_i. bgtz: !neg_i & !zero_i.
  - pc_write = taken. Go to FETCH.
- JUMP: pc_write=1, pc_src=2. For jal also reg_write=1, reg_dst=2, mem_to_reg=2; the PC already holds PC+4. Go to FETCH.
- JR: pc_write=1, pc_src=3, go to FETCH.
- Memory wait counter:
  - Cleared on entry to FETCH, MEM_RD and MEM_WR, and whenever mem_ready_i=1.
  - If the counter reaches MEM_TIMEOUT while mem_ready_i=0 -> FAULT.
  - mem_ready_i=1 in that same cycle completes normally; ready wins.
- FAULT:
  - Terminal state, left only by rst_i. fault_o=1.
  - All strobes are 0 and mem_req is dropped immediately.
- mem_ready_i is ignored while mem_req_o=0.
- Latency with zero-wait memory (ready in the first request cycle):
  - R-type/I-type ALU: 4 cycles. lw: 5. sw: 4. branch: 3. j/jal/jr: 3.
- Reset asserted mid-instruction aborts it: no reg_write or pc_write is issued in the reset cycle.

Decomposition:
- Package mc_ctrl_pkg holds:
  - State enum (4-bit): FETCH, DECODE, EXEC_R, EXEC_I, WB_ALU, ADDR, MEM_RD, MEM_WR, WB_MEM, BRANCH, JUMP, JR, FAULT.
  - Opcode constants and FUNCT_JR.
  - ALUOp, pc_src, alu_src_b, reg_dst and mem_to_reg encodings.
- One sub-module, mc_branch_eval: combinational taken logic from opcode, zero and neg. Everything else stays in multicycle_ctrl.

Test Plan:
- add (op 0x00, funct 0x20) with ready always 1 -> states FETCH, DECODE, EXEC_R, WB_ALU; exactly one reg_write with reg_dst=1; pc_write exactly once in FETCH.
- lw (0x23) with ready delayed 3 cycles in FETCH and 2 in MEM_RD -> mem_req held throughout, iord=0 then 1; ir_write pulses once; reg_write with mem_to_reg=1 at cycle 10.
- beq with zero_i=1, then bne with zero_i=1 -> pc_write=1 with pc_src=1 in BRANCH for beq; pc_write=0 for bne.
- blez/bgtz with neg_i=1, zero_i=0 -> blez taken, bgtz not taken.
- jal (0x03) -> JUMP asserts pc_write, pc_src=2, reg_write, reg_dst=2, mem_to_reg=2 in one cycle. jr (funct 0x08) -> pc_src=3.
- Opcode 0x3F -> FAULT after DECODE, fault_o=1.
- Ready withheld 15 cycles in MEM_WR -> FAULT. rst_i=1 for one cycle -> state_o=FETCH, fault_o=0, no strobes.
